add_1bit_result_checker: RTL
============================

ADD_1BIT_RESULT_CHECKER -- requirements
Module: add_1bit_result_checker

Interface
REQ-001 Parameter NUM_VECTORS, default 504, number of result samples per run (4 directed + 500 random); legal range 1..2**CNT_W-1.
REQ-002 Parameter CNT_W, default 16, width of all counters and index outputs.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, single-cycle pulse that begins a run.
REQ-006 Port in_valid, input, 1, a result sample is presented this cycle.
REQ-007 Port in_ready, output, 1, checker accepts a sample this cycle.
REQ-008 Port stim_a, input, 1, stimulus a applied for this sample.
REQ-009 Port stim_b, input, 1, stimulus b applied for this sample.
REQ-010 Port golden_c, input, 1, RTL-model result for this sample.
REQ-011 Port netlist_c, input, 1, post-route netlist result for this sample.
REQ-012 Port busy, output, 1, run in progress.
REQ-013 Port done, output, 1, run complete; held until the next run starts or reset.
REQ-014 Port pass, output, 1, valid only while done=1; 1 when no mismatch occurred.
REQ-015 Port vec_cnt, output, CNT_W, samples accepted in the current or last run.
REQ-016 Port mismatch_cnt, output, CNT_W, mismatching samples, saturating at all-ones.
REQ-017 Port first_fail_idx, output, CNT_W, vec_cnt value at the first mismatch; all-ones if none.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 IDLE->RUN on start=1; vec_cnt, mismatch_cnt and captures cleared in the same edge.
REQ-020 DONE->RUN on start=1 with the same clearing; start is ignored in RUN.
REQ-021 in_ready SHALL equal 1 only in RUN; busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-022 A sample is accepted when in_valid & in_ready; samples presented outside RUN are dropped without effect.
REQ-023 On an accepted sample vec_cnt SHALL increment by 1, visible on the following cycle.
REQ-024 A sample mismatches when golden_c != netlist_c; mismatch_cnt SHALL then increment on the same edge, holding at 2**CNT_W-1 rather than wrapping.
REQ-025 first_fail_idx SHALL capture the pre-increment vec_cnt on the first mismatch of a run only.
REQ-026 Acceptance of sample number NUM_VECTORS SHALL move RUN->DONE on the same edge, so done rises one cycle after the last accept.
REQ-027 pass SHALL equal (mismatch_cnt==0) while done=1 and 0 otherwise.
REQ-028 in_valid low cycles in RUN SHALL stall the run with no timeout.
REQ-029 No combinational path from in_valid to in_ready.

Reset
REQ-030 On rst=1 at a clock edge, state=IDLE and in_ready=0, busy=0, done=0, pass=0, vec_cnt=0, mismatch_cnt=0, first_fail_idx=all-ones.
REQ-031 rst SHALL take priority over start and in_valid in the same cycle; a run interrupted by reset is discarded.

Configuration
REQ-032 Macro FIRST_FAIL_CAPTURE_EN defined: add outputs fail_a, fail_b, fail_golden, fail_netlist (1 bit each), capturing stim_a, stim_b, golden_c, netlist_c of the first mismatch alongside first_fail_idx; reset and start clear them to 0.
REQ-033 Macro undefined: these four ports and their registers SHALL not exist; all other behaviour identical.

Verification
REQ-034 NUM_VECTORS=4, start, then 4 accepted samples golden_c=netlist_c -> done=1 one cycle after 4th accept, pass=1, vec_cnt=4, mismatch_cnt=0, first_fail_idx=all-ones.
REQ-035 NUM_VECTORS=4, sample 2 (index 2) has golden_c=1, netlist_c=0, a=0, b=1 -> mismatch_cnt=1, first_fail_idx=2, pass=0; with macro, fail_a=0, fail_b=1, fail_golden=1, fail_netlist=0.
REQ-036 CNT_W=3, NUM_VECTORS=7, all 7 samples mismatch -> mismatch_cnt=7 saturated, first_fail_idx=0.
REQ-037 in_valid=1 before start, then start and in_valid gaps -> pre-start samples not counted; done only after exactly NUM_VECTORS accepts.
REQ-038 rst asserted after 2 accepts in RUN, then start -> state IDLE, counters 0 after reset; new run counts from 0 and completes normally.
REQ-039 start in DONE -> RUN next cycle, done=0, vec_cnt=0, mismatch_cnt=0.

Source files
------------

// File: rtl/add_1bit_result_checker.sv
// Compares golden vs netlist results of a 1-bit adder over a run of NUM_VECTORS samples.
// Optional first-mismatch stimulus capture is enabled by defining FIRST_FAIL_CAPTURE_EN.
module add_1bit_result_checker #(
  parameter int NUM_VECTORS = 504,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stim_a,
  input  logic             stim_b,
  input  logic             golden_c,
  input  logic             netlist_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic             fail_a,
  output logic             fail_b,
  output logic             fail_golden,
  output logic             fail_netlist
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;

  logic accept_s;
  logic mismatch_s;
  logic clear_s;
  logic capture_s;

  // in_ready depends only on state, so in_valid never reaches it combinationally.
  assign accept_s   = in_valid & (state_q == RUN);
  assign mismatch_s = golden_c ^ netlist_c;
  assign clear_s    = start & ((state_q == IDLE) | (state_q == DONE));
  assign capture_s  = accept_s & mismatch_s & (mm_cnt_q == ZERO);

  // Next-state and counter update logic.
  always_comb begin
    state_d   = state_q;
    vec_cnt_d = vec_cnt_q;
    mm_cnt_d  = mm_cnt_q;
    ffi_d     = ffi_q;
    case (state_q)
      IDLE, DONE: begin
        if (clear_s) begin
          state_d   = RUN;
          vec_cnt_d = ZERO;
          mm_cnt_d  = ZERO;
          ffi_d     = ALL_ONES;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (accept_s) begin
          vec_cnt_d = vec_cnt_q + ONE;
          if (mismatch_s && (mm_cnt_q != ALL_ONES)) begin
            mm_cnt_d = mm_cnt_q + ONE;
          end else begin
            mm_cnt_d = mm_cnt_q;
          end
          if (capture_s) begin
            ffi_d = vec_cnt_q;
          end else begin
            ffi_d = ffi_q;
          end
          if (vec_cnt_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_cnt_q <= ZERO;
      mm_cnt_q  <= ZERO;
      ffi_q     <= ALL_ONES;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      mm_cnt_q  <= mm_cnt_d;
      ffi_q     <= ffi_d;
    end
  end

  assign in_ready       = (state_q == RUN);
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = (state_q == DONE) & (mm_cnt_q == ZERO);
  assign vec_cnt        = vec_cnt_q;
  assign mismatch_cnt   = mm_cnt_q;
  assign first_fail_idx = ffi_q;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [3:0] fail_q, fail_d;

  // Snapshot of the stimulus and both results at the first mismatch of a run.
  always_comb begin
    fail_d = fail_q;
    if (clear_s) begin
      fail_d = 4'b0000;
    end else if (capture_s) begin
      fail_d = {stim_a, stim_b, golden_c, netlist_c};
    end else begin
      fail_d = fail_q;
    end
  end

  // First-mismatch capture register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_q <= 4'b0000;
    end else begin
      fail_q <= fail_d;
    end
  end

  assign fail_a       = fail_q[3];
  assign fail_b       = fail_q[2];
  assign fail_golden  = fail_q[1];
  assign fail_netlist = fail_q[0];
`endif

endmodule
